// File: rtl/axis_rx_frame_fifo_pkg.sv
// Shared types and constants for the packet-mode RX frame FIFO.
package axis_rx_frame_fifo_pkg;

    localparam int STAT_W = 32;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } fifo_state_e;

endpackage

// File: rtl/axis_rx_frame_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read, no reset.
module axis_rx_frame_fifo_mem #(
    parameter int WIDTH  = 73,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_rx_frame_fifo.sv
// Packet-mode RX FIFO: releases only complete frames, 1 cycle tlast-write to m_axis_tvalid; s_axis_tready=!full,
// overflowing frames are dropped whole. Define AXIS_RX_FRAME_FIFO_STATS_EN for frames_ok/frames_dropped counters.
module axis_rx_frame_fifo
    import axis_rx_frame_fifo_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk156,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   level,
    output logic              drop_pulse
`ifdef AXIS_RX_FRAME_FIFO_STATS_EN
    ,
    output logic [STAT_W-1:0] frames_ok,
    output logic [STAT_W-1:0] frames_dropped
`endif
);

    localparam int              ENTRY_W  = DATA_W + KEEP_W + 1;
    localparam logic [ADDR_W:0] PTR_ONE  = 1;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    fifo_state_e       state_q, state_d;
    logic [ADDR_W:0]   wr_spec_q, wr_spec_d;
    logic [ADDR_W:0]   wr_commit_q, wr_commit_d;
    logic [ADDR_W:0]   rd_q, rd_d;
    logic              drop_q;

    logic              full;
    logic              do_write;
    logic              do_commit;
    logic              do_rewind;
    logic              do_read;
    logic [ENTRY_W-1:0] rd_entry;

    // Full is taken from pre-edge pointers so s_axis_tready never depends on m_axis_tready.
    assign full          = (wr_spec_q - rd_q) == FULL_LVL;
    assign s_axis_tready = !full;
    assign m_axis_tvalid = wr_commit_q != rd_q;
    assign level         = wr_spec_q - rd_q;
    assign drop_pulse    = drop_q;
    assign do_read       = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk156 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ACCEPT;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            rd_q        <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_spec_q   <= wr_spec_d;
            wr_commit_q <= wr_commit_d;
            rd_q        <= rd_d;
            drop_q      <= do_rewind;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT:  if (s_axis_tvalid && full && !s_axis_tlast) state_d = DISCARD;
            DISCARD: if (s_axis_tvalid && s_axis_tlast)          state_d = ACCEPT;
        endcase
    end

    always_comb begin
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_rewind = 1'b0;
        if (state_q == ACCEPT && s_axis_tvalid) begin
            if (!full) begin
                do_write  = 1'b1;
                do_commit = s_axis_tlast;
            end else begin
                do_rewind = 1'b1;
            end
        end
    end

    // Rewind only discards the speculative tail; committed entries at or above rd stay put.
    always_comb begin
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        rd_d        = rd_q;
        if (do_write)  wr_spec_d   = wr_spec_q + PTR_ONE;
        if (do_commit) wr_commit_d = wr_spec_q + PTR_ONE;
        if (do_rewind) wr_spec_d   = wr_commit_q;
        if (do_read)   rd_d        = rd_q + PTR_ONE;
    end

    axis_rx_frame_fifo_mem #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk156),
        .we_i    (do_write),
        .waddr_i (wr_spec_q[ADDR_W-1:0]),
        .wdata_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .raddr_i (rd_q[ADDR_W-1:0]),
        .rdata_o (rd_entry)
    );

    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_entry;

`ifdef AXIS_RX_FRAME_FIFO_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = 1;

    logic [STAT_W-1:0] frames_ok_q;
    logic [STAT_W-1:0] frames_dropped_q;

    always_ff @(posedge clk156 or negedge resetn) begin
        if (!resetn) begin
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            if (do_commit && frames_ok_q != '1) frames_ok_q <= frames_ok_q + STAT_ONE;
            if (drop_q && frames_dropped_q != '1) frames_dropped_q <= frames_dropped_q + STAT_ONE;
        end
    end

    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
`endif

endmodule

// File: tb/tb_axis_rx_frame_fifo.sv
// Directed self-checking bench for axis_rx_frame_fifo at DEPTH=16.
`timescale 1ns/100ps
module tb_axis_rx_frame_fifo;

    logic        clk156 = 1'b0;
    logic        resetn;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [4:0]  level;
    logic        drop_pulse;
`ifdef AXIS_RX_FRAME_FIFO_STATS_EN
    logic [31:0] frames_ok;
    logic [31:0] frames_dropped;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #3 clk156 = ~clk156;

    axis_rx_frame_fifo dut (
        .clk156        (clk156),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .level         (level),
        .drop_pulse    (drop_pulse)
`ifdef AXIS_RX_FRAME_FIFO_STATS_EN
        ,
        .frames_ok     (frames_ok),
        .frames_dropped(frames_dropped)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Pops n single-beat frames with data base+i, checking each head before it is taken.
    task automatic drain_singles(input string tag, input int n, input logic [63:0] base);
        m_axis_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vld"},  {63'd0, m_axis_tvalid}, 64'd1);
            chk({tag, "_data"}, m_axis_tdata, base + 64'(i));
            chk({tag, "_last"}, {63'd0, m_axis_tlast}, 64'd1);
            tick();
        end
        m_axis_tready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] single_vals [4];
        single_vals[0] = 64'hA;
        single_vals[1] = 64'hB;
        single_vals[2] = 64'hC;
        single_vals[3] = 64'hD;

        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();

        chk("rst_vld",   {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_rdy",   {63'd0, s_axis_tready}, 64'd1);
        chk("rst_drop",  {63'd0, drop_pulse}, 64'd0);
        resetn = 1'b1;
        tick();

        // Single-beat frames streamed straight through.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(single_vals[i], 8'hFF, 1'b1);
            chk("s1_vld",   {63'd0, m_axis_tvalid}, 64'd1);
            chk("s1_data",  m_axis_tdata, single_vals[i]);
            chk("s1_level", 64'(level), 64'd1);
            chk("s1_drop",  {63'd0, drop_pulse}, 64'd0);
        end
        tick();
        chk("s1_level_end", 64'(level), 64'd0);
        chk("s1_vld_end",   {63'd0, m_axis_tvalid}, 64'd0);
        m_axis_tready = 1'b0;

        // 5-beat frame held until its tlast is stored.
        for (int i = 0; i < 5; i++) begin
            send(64'h10 + 64'(i), (i == 4) ? 8'h0F : 8'hFF, i == 4);
            chk("s2_vld",   {63'd0, m_axis_tvalid}, (i == 4) ? 64'd1 : 64'd0);
            chk("s2_level", 64'(level), 64'(i + 1));
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("s2_data", m_axis_tdata, 64'h10 + 64'(i));
            chk("s2_keep", 64'(m_axis_tkeep), (i == 4) ? 64'h0F : 64'hFF);
            chk("s2_last", {63'd0, m_axis_tlast}, (i == 4) ? 64'd1 : 64'd0);
            tick();
        end
        m_axis_tready = 1'b0;
        chk("s2_vld_end", {63'd0, m_axis_tvalid}, 64'd0);

        // 14 committed entries, then a 4-beat frame that overflows on beat 3.
        for (int i = 0; i < 14; i++) send(64'h100 + 64'(i), 8'hFF, 1'b1);
        chk("s3_level14", 64'(level), 64'd14);
        send(64'h200, 8'hFF, 1'b0);
        chk("s3_level15", 64'(level), 64'd15);
        send(64'h201, 8'hFF, 1'b0);
        chk("s3_level16", 64'(level), 64'd16);
        chk("s3_full_rdy", {63'd0, s_axis_tready}, 64'd0);
        send(64'h202, 8'hFF, 1'b0);
        chk("s3_drop",       {63'd0, drop_pulse}, 64'd1);
        chk("s3_level_rew",  64'(level), 64'd14);
        send(64'h203, 8'hFF, 1'b1);
        chk("s3_drop_once",  {63'd0, drop_pulse}, 64'd0);
        chk("s3_level_b4",   64'(level), 64'd14);
        drain_singles("s3_drain", 14, 64'h100);
        chk("s3_empty", {63'd0, m_axis_tvalid}, 64'd0);
        send(64'h300, 8'hFF, 1'b1);
        chk("s3_accept_level", 64'(level), 64'd1);
        drain_singles("s3_accept", 1, 64'h300);

        // 20-beat frame can never fit.
        for (int i = 0; i < 20; i++) begin
            send(64'h400 + 64'(i), 8'hFF, i == 19);
            if (i == 15) begin
                chk("s4_level16", 64'(level), 64'd16);
                chk("s4_vld_spec", {63'd0, m_axis_tvalid}, 64'd0);
            end
            if (i == 16) begin
                chk("s4_drop",  {63'd0, drop_pulse}, 64'd1);
                chk("s4_level", 64'(level), 64'd0);
            end
        end
        chk("s4_level_end", 64'(level), 64'd0);
        chk("s4_vld_end",   {63'd0, m_axis_tvalid}, 64'd0);
        send(64'h500, 8'hFF, 1'b0);
        send(64'h501, 8'h03, 1'b1);
        chk("s4_level2", 64'(level), 64'd2);
        m_axis_tready = 1'b1;
        chk("s4_d0",    m_axis_tdata, 64'h500);
        chk("s4_l0",    {63'd0, m_axis_tlast}, 64'd0);
        tick();
        chk("s4_d1",    m_axis_tdata, 64'h501);
        chk("s4_k1",    64'(m_axis_tkeep), 64'h03);
        chk("s4_l1",    {63'd0, m_axis_tlast}, 64'd1);
        tick();
        m_axis_tready = 1'b0;
        chk("s4_empty", {63'd0, m_axis_tvalid}, 64'd0);

        // Full FIFO, beat arrives while a read happens in the same cycle.
        for (int i = 0; i < 16; i++) send(64'h600 + 64'(i), 8'hFF, i == 15);
        chk("s5_level16", 64'(level), 64'd16);
        chk("s5_vld",     {63'd0, m_axis_tvalid}, 64'd1);
        chk("s5_rdy",     {63'd0, s_axis_tready}, 64'd0);
        m_axis_tready = 1'b1;
        send(64'h6FF, 8'hFF, 1'b1);
        m_axis_tready = 1'b0;
        chk("s5_level15", 64'(level), 64'd15);
        chk("s5_drop",    {63'd0, drop_pulse}, 64'd1);
        chk("s5_head",    m_axis_tdata, 64'h601);
        m_axis_tready = 1'b1;
        repeat (15) tick();
        m_axis_tready = 1'b0;
        chk("s5_empty",   64'(level), 64'd0);

        // Mid-frame asynchronous reset with committed and speculative content.
        for (int i = 0; i < 7; i++) send(64'h700 + 64'(i), 8'hFF, i == 2);
        chk("s6_level7", 64'(level), 64'd7);
        chk("s6_vld",    {63'd0, m_axis_tvalid}, 64'd1);
`ifdef AXIS_RX_FRAME_FIFO_STATS_EN
        chk("s6_ok_cnt",   64'(frames_ok), 64'd23);
        chk("s6_drop_cnt", 64'(frames_dropped), 64'd3);
`endif
        resetn = 1'b0;
        #1;
        chk("s6_rst_vld",   {63'd0, m_axis_tvalid}, 64'd0);
        chk("s6_rst_level", 64'(level), 64'd0);
        chk("s6_rst_rdy",   {63'd0, s_axis_tready}, 64'd1);
        chk("s6_rst_drop",  {63'd0, drop_pulse}, 64'd0);
`ifdef AXIS_RX_FRAME_FIFO_STATS_EN
        chk("s6_rst_ok",   64'(frames_ok), 64'd0);
        chk("s6_rst_drp",  64'(frames_dropped), 64'd0);
`endif
        tick();
        resetn = 1'b1;
        tick();
        send(64'h800, 8'h01, 1'b1);
        chk("s6_post_level", 64'(level), 64'd1);
        chk("s6_post_keep",  64'(m_axis_tkeep), 64'h01);
        drain_singles("s6_post", 1, 64'h800);
        chk("s6_post_empty", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_rx_frame_fifo.md
# axis_rx_frame_fifo

Packet-mode receive FIFO sitting directly downstream of the socket loopback stage on the 156.25 MHz AXI-Stream RX path. The loopback source drives `rx_axis_tvalid` without honouring `tready`, so this block absorbs its beats, holds each frame until its `tlast` beat is stored, and releases only complete frames to the consumer. Frames that overflow the buffer are dropped whole rather than truncated.

## Interface
- `DATA_W`, 64, data width in bits.
- `KEEP_W`, `DATA_W/8`, keep width.
- `DEPTH`, 16, entries; power of two, ≥4.
- `ADDR_W`, `$clog2(DEPTH)`, derived; not overridden.
- `clk156` input 1, the only clock.
- `resetn` input 1, asynchronous active-low reset.
- `s_axis_tdata` input DATA_W, beat from the loopback RX output.
- `s_axis_tkeep` input KEEP_W, byte enables.
- `s_axis_tvalid` input 1, beat valid; the source does not honour tready.
- `s_axis_tready` output 1, `!full`.
- `s_axis_tlast` input 1, end of frame.
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tlast` output DATA_W / KEEP_W / 1, head entry.
- `m_axis_tvalid` output 1, a committed entry is available.
- `m_axis_tready` input 1, consumer accept.
- `level` output ADDR_W+1, entries used, committed plus speculative.
- `drop_pulse` output 1, one-cycle pulse per dropped frame.

## Operation
- Pointers are ADDR_W+1 bits wide, with the MSB used for wrap: `wr_spec`, `wr_commit`, `rd`.
- `full` = (`wr_spec`−`rd`)==DEPTH.
- `m_axis_tvalid` = `wr_commit`!=`rd`.
- FSM has two states.
- **ACCEPT**
  - If `s_tvalid` and not full: store the beat at `wr_spec` and increment it. If `tlast`, set `wr_commit` to the new `wr_spec`.
  - If `s_tvalid` and full: rewind `wr_spec` to `wr_commit` and pulse `drop_pulse`. If the beat has `tlast`, stay in ACCEPT; otherwise go to DISCARD.
- **DISCARD**
  - Every valid beat is dropped and the pointers are unchanged.
  - A beat with `tlast` returns the FSM to ACCEPT. That beat is also dropped.
- Read: `m_tvalid && m_tready` increments `rd`. The outputs show `mem[rd]` combinationally, first-word fall-through.
- Read and write in the same cycle are both performed.
- `full` is evaluated on pre-edge state. A beat arriving while full is dropped even if a read happens the same cycle. This keeps a combinational path out of `s_tready` ← `m_tready`.
- A frame longer than DEPTH can never commit. It is always dropped, and the FIFO then recovers with no leaked entries.
- A rewind never moves `wr_spec` below `rd`, because committed data is untouched.

## Timing
- Reset (async, `resetn`=0):
  - All pointers are 0 and the FSM is in ACCEPT.
  - `m_axis_tvalid`=0, `drop_pulse`=0, `level`=0, `s_axis_tready`=1.
  - `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` are don't-care while `m_tvalid`=0.
- Latency: a `tlast` beat written at edge N makes its frame's head valid after edge N. Minimum write-to-`m_tvalid` latency is 1 cycle.
- `drop_pulse` is high for exactly the cycle after the overflowing edge. It is registered.
- Reset mid-frame discards all content, committed and speculative.
- The memory array has no reset.

## Configuration
- `AXIS_RX_FRAME_FIFO_STATS_EN` defined:
  - Adds output `frames_ok` [31:0], counting committed frames.
  - Adds output `frames_dropped` [31:0], counting `drop_pulse` events.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: neither port nor either counter exists, and all other behaviour is identical.

## Structure
- `axis_rx_frame_fifo_pkg` holds:
  - the state enum `fifo_state_e` {ACCEPT, DISCARD};
  - the counter width constant `STAT_W`=32.
- Sub-module `axis_rx_frame_fifo_mem`:
  - simple dual-port register array, DEPTH × (DATA_W+KEEP_W+1);
  - synchronous write, combinational read;
  - no reset.

## Test plan
All scenarios use DEPTH=16.
- Reset, then single-beat frames 0xA..0xD, each with `tlast`, with `m_tready`=1 → the same 4 beats appear in order, each 1 cycle after write, `level` returns to 0, and `drop_pulse` never fires.
- A 5-beat frame with `m_tready`=0 → `m_tvalid` stays 0 until beat 5 is written, then is 1 with `level`=5. Draining yields 5 beats with `tlast` only on the last.
- Fill 14 committed entries, then send a 4-beat frame → beat 3 hits full, `drop_pulse`=1 for 1 cycle, and `level` returns to 14. Beat 4 is dropped and the FSM is back in ACCEPT. Draining yields exactly the 14 committed beats.
- A 20-beat frame into an empty FIFO → frame dropped, `level`=0, no `m_tvalid`. A following 2-beat frame passes intact.
- Full FIFO with simultaneous `m_tready` and `s_tvalid` → the beat is dropped and the read is performed, leaving `level`=15.
- Assert `resetn`=0 mid-frame with 7 entries → all outputs take reset values asynchronously. After release, a new 1-beat frame passes. With STATS_EN, both counters read 0 after reset.
